// File: rtl/nco_pkg.sv
// Shared constants for the numerically controlled oscillator.
// Dither LFSR constants are only consumed when NCO_DITHER_EN is defined.
package nco_pkg;

    localparam int NCO_LATENCY = 3;

    localparam logic [31:0] NCO_LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] NCO_LFSR_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_e;

endpackage

// File: rtl/nco_sin_lut.sv
// Quarter-wave sine ROM with one-cycle registered read.
// Entries sit on half-sample phases so the quadrant mirror is exact.
module nco_sin_lut
    import nco_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] data
);

    localparam int  DEPTH = 1 << AWIDTH;
    localparam real PI    = 3.14159265358979323846;

    function automatic logic [DWIDTH-1:0] entry(input int k);
        real amp;
        real ang;
        amp = real'((1 << (DWIDTH - 1)) - 1);
        ang = 2.0 * PI * (real'(k) + 0.5) / real'(4 * DEPTH);
        return DWIDTH'($rtoi(amp * $sin(ang) + 0.5));
    endfunction

    logic [DWIDTH-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = entry(k);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/nco.sv
// Phase-accumulator NCO with quarter-wave folding, 3-cycle acc-to-lo latency.
// Define NCO_DITHER_EN to add LFSR phase dither ahead of truncation.
module nco
    import nco_pkg::*;
#(
    parameter int DWIDTH     = 16,
    parameter int PWIDTH     = 32,
    parameter int LUT_AWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     fcw_load,
    input  logic [PWIDTH-1:0]        fcw,
    input  logic [PWIDTH-1:0]        phase_ofs,
    output logic signed [DWIDTH-1:0] lo,
    output logic                     lo_valid,
    output logic                     wrap
);

    localparam int IWIDTH = LUT_AWIDTH - 2;
    localparam int TRUNC  = PWIDTH - LUT_AWIDTH;

    logic [PWIDTH-1:0]     acc;
    logic [PWIDTH-1:0]     fcw_reg;
    logic [PWIDTH-1:0]     dither;
    logic [LUT_AWIDTH-1:0] addr;
    quad_e                 quad;
    logic [IWIDTH-1:0]     idx_d;
    logic                  neg_d;
    logic [IWIDTH-1:0]     idx_q;
    logic                  neg_s1;
    logic                  neg_s2;
    logic [DWIDTH-1:0]     rom_q;
    logic [2:0]            vld_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            fcw_reg <= '0;
            wrap    <= 1'b0;
        end else begin
            if (en) begin
                {wrap, acc} <= {1'b0, acc} + {1'b0, fcw_reg};
            end else begin
                wrap <= 1'b0;
            end
            if (fcw_load) begin
                fcw_reg <= fcw;
            end
        end
    end

`ifdef NCO_DITHER_EN
    logic [31:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= NCO_LFSR_SEED;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ NCO_LFSR_POLY;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

    assign dither = PWIDTH'(lfsr[TRUNC-1:0]);
`else
    assign dither = '0;
`endif

    assign addr = LUT_AWIDTH'((acc + phase_ofs + dither) >> TRUNC);
    assign quad = quad_e'(addr[LUT_AWIDTH-1 -: 2]);

    // Odd quadrants run the quarter wave backwards, the lower half-cycle negates.
    always_comb begin
        idx_d = addr[IWIDTH-1:0];
        neg_d = 1'b0;
        unique case (quad)
            QUAD_0: ;
            QUAD_1: idx_d = ~addr[IWIDTH-1:0];
            QUAD_2: neg_d = 1'b1;
            QUAD_3: begin
                idx_d = ~addr[IWIDTH-1:0];
                neg_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            neg_s1 <= 1'b0;
            neg_s2 <= 1'b0;
            lo     <= '0;
        end else begin
            idx_q  <= idx_d;
            neg_s1 <= neg_d;
            neg_s2 <= neg_s1;
            lo     <= neg_s2 ? -$signed(rom_q) : $signed(rom_q);
        end
    end

    nco_sin_lut #(
        .DWIDTH(DWIDTH),
        .AWIDTH(IWIDTH)
    ) u_lut (
        .clk (clk),
        .rst (rst),
        .addr(idx_q),
        .data(rom_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr   <= '0;
            lo_valid <= 1'b0;
        end else begin
            vld_sr   <= {vld_sr[1:0], en};
            lo_valid <= vld_sr[2];
        end
    end

endmodule
